// File: rtl/debounce_sync.sv
// Two/three/four-flop synchroniser plus consecutive-sample debounce FSM with glitch counter.
// Optional edge strobes are built only when DEBOUNCE_EDGE_STROBE_EN is defined.
module debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       x_raw,
    input  logic       glitch_clr,
    output logic       x_clean,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic [7:0] glitch_cnt
);

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_TO_HIGH = 2'd1,
        ST_HIGH    = 2'd2,
        ST_TO_LOW  = 2'd3
    } state_t;

    localparam bit             SINGLE    = (STABLE_CYCLES == 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_M1 = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   x_clean_q, x_clean_d;
    logic [7:0]             glitch_cnt_q, glitch_cnt_d;
    logic                   abort_s;

    // Synchroniser chain: the only consumer of x_raw.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], x_raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Next-state logic: count consecutive opposite samples, abort on any reversion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort_s = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (s) begin
                    if (SINGLE) begin
                        state_d = ST_HIGH;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_TO_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    state_d = ST_LOW;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_TO_HIGH: begin
                if (!s) begin
                    state_d = ST_LOW;
                    cnt_d   = CNT_ZERO;
                    abort_s = 1'b1;
                end else if (cnt_q == STABLE_M1) begin
                    state_d = ST_HIGH;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!s) begin
                    if (SINGLE) begin
                        state_d = ST_LOW;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_TO_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    state_d = ST_HIGH;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_TO_LOW: begin
                if (s) begin
                    state_d = ST_HIGH;
                    cnt_d   = CNT_ZERO;
                    abort_s = 1'b1;
                end else if (cnt_q == STABLE_M1) begin
                    state_d = ST_LOW;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Clear wins over a same-cycle abort; the count sticks at 255.
    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        if (glitch_clr) begin
            glitch_cnt_d = 8'd0;
        end else if (abort_s && (glitch_cnt_q != 8'd255)) begin
            glitch_cnt_d = glitch_cnt_q + 8'd1;
        end else begin
            glitch_cnt_d = glitch_cnt_q;
        end
    end

    assign x_clean_d = (state_d == ST_HIGH) || (state_d == ST_TO_LOW);

    // FSM state, counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_LOW;
            cnt_q        <= CNT_ZERO;
            x_clean_q    <= 1'b0;
            glitch_cnt_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            x_clean_q    <= x_clean_d;
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign x_clean    = x_clean_q;
    assign glitch_cnt = glitch_cnt_q;

`ifdef DEBOUNCE_EDGE_STROBE_EN
    logic rise_q, fall_q;

    // Strobes line up with the cycle x_clean first shows its new level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= x_clean_d & ~x_clean_q;
            fall_q <= ~x_clean_d & x_clean_q;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
`else
    assign rise_pulse = 1'b0;
    assign fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: default instance plus a STABLE_CYCLES=1 instance, both
// checked against a sample-window reference model.
module tb_debounce_sync;

    localparam bit STROBE_EN =
`ifdef DEBOUNCE_EDGE_STROBE_EN
        1'b1;
`else
        1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       x_raw;
    logic       glitch_clr;
    logic       x_clean, rise_pulse, fall_pulse;
    logic [7:0] glitch_cnt;
    logic       x_clean1, rise_pulse1, fall_pulse1;
    logic [7:0] glitch_cnt1;
    logic [21:0] obs_v;

    int total = 0;
    int bad   = 0;

    debounce_sync dut (
        .clk(clk), .rst(rst), .x_raw(x_raw), .glitch_clr(glitch_clr),
        .x_clean(x_clean), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .glitch_cnt(glitch_cnt)
    );

    debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .x_raw(x_raw), .glitch_clr(glitch_clr),
        .x_clean(x_clean1), .rise_pulse(rise_pulse1), .fall_pulse(fall_pulse1),
        .glitch_cnt(glitch_cnt1)
    );

    assign obs_v = {x_clean, rise_pulse, fall_pulse, glitch_cnt,
                    x_clean1, rise_pulse1, fall_pulse1, glitch_cnt1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw-input history, synchronised-sample history, per-instance outputs.
    logic       rq[$];
    logic       sq[$];
    int         stab[2] = '{4, 1};
    logic       m_clean[2];
    logic       m_rise[2];
    logic       m_fall[2];
    logic [7:0] m_g[2];

    function automatic logic [21:0] exp_vec();
        return {m_clean[0], m_rise[0], m_fall[0], m_g[0],
                m_clean[1], m_rise[1], m_fall[1], m_g[1]};
    endfunction

    task automatic model_reset();
        rq = {};
        sq = {};
        for (int i = 0; i < 8; i++) begin
            rq.push_back(1'b0);
            sq.push_back(1'b0);
        end
        for (int j = 0; j < 2; j++) begin
            m_clean[j] = 1'b0;
            m_rise[j]  = 1'b0;
            m_fall[j]  = 1'b0;
            m_g[j]     = 8'd0;
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model, settle past the edge.
    task automatic step(input logic xr, input logic clr);
        logic dummy, old, flip, inc;
        x_raw      = xr;
        glitch_clr = clr;
        @(posedge clk);
        rq.push_front(xr);
        dummy = rq.pop_back();
        sq.push_front(rq[2]);
        dummy = sq.pop_back();
        for (int j = 0; j < 2; j++) begin
            old  = m_clean[j];
            flip = 1'b1;
            for (int i = 0; i < stab[j]; i++) begin
                if (sq[i] == old) flip = 1'b0;
            end
            inc        = !flip && (sq[0] == old) && (sq[1] != old);
            m_clean[j] = flip ? ~old : old;
            m_rise[j]  = STROBE_EN && flip && !old;
            m_fall[j]  = STROBE_EN && flip && old;
            if (clr) m_g[j] = 8'd0;
            else if (inc && (m_g[j] != 8'd255)) m_g[j] = m_g[j] + 8'd1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; x_raw = 1'b0; glitch_clr = 1'b0;
        model_reset();
        #12;
        if (obs_v !== 22'h0) begin
            bad++; $display("FAIL reset_initial: got %h exp %h", obs_v, 22'h0);
        end
        total++;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
        if (obs_v !== exp_vec()) begin
            bad++; $display("FAIL reset_pre_model: got %h exp %h", obs_v, exp_vec());
        end
        total++;
        #2 rst = 1'b0;
        #1;
        if (obs_v !== 22'h0) begin
            bad++; $display("FAIL reset_async: got %h exp %h", obs_v, 22'h0);
        end
        total++;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        model_reset();
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b0);
            if ({x_clean, rise_pulse} !== {k == 6, STROBE_EN && (k == 6)}) begin
                bad++; $display("FAIL reset_requalify k=%0d: got %b%b exp %b%b", k,
                                x_clean, rise_pulse, k == 6, STROBE_EN && (k == 6));
            end
            total++;
            if (obs_v !== exp_vec()) begin
                bad++; $display("FAIL reset_model: got %h exp %h", obs_v, exp_vec());
            end
            total++;
        end
    endtask

    task automatic test_clean_rise();
        for (int k = 0; k < 12; k++) step(1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b0);
            if ({x_clean, rise_pulse} !== {k >= 6, STROBE_EN && (k == 6)}) begin
                bad++; $display("FAIL clean_rise k=%0d: got %b%b exp %b%b", k,
                                x_clean, rise_pulse, k >= 6, STROBE_EN && (k == 6));
            end
            total++;
            if (obs_v !== exp_vec()) begin
                bad++; $display("FAIL clean_rise_model: got %h exp %h", obs_v, exp_vec());
            end
            total++;
        end
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 10; k++) step(1'b0, k == 0);
        for (int r = 0; r < 300; r++) begin
            for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
            for (int k = 0; k < int'($urandom_range(4, 7)); k++) step(1'b0, 1'b0);
            if (obs_v !== exp_vec()) begin
                bad++; $display("FAIL glitch_model r=%0d: got %h exp %h", r, obs_v, exp_vec());
            end
            total++;
            if (x_clean !== 1'b0) begin
                bad++; $display("FAIL glitch_clean r=%0d: got %b exp 0", r, x_clean);
            end
            total++;
            if (r == 0) begin
                if (glitch_cnt !== 8'd1) begin
                    bad++; $display("FAIL glitch_first: got %0d exp 1", glitch_cnt);
                end
                total++;
            end
        end
        if (glitch_cnt !== 8'd255) begin
            bad++; $display("FAIL glitch_saturate: got %0d exp 255", glitch_cnt);
        end
        total++;
    endtask

    task automatic test_to_low_abort();
        int falls = 0;
        step(1'b1, 1'b1);
        for (int k = 0; k < 11; k++) step(1'b1, 1'b0);
        for (int k = 0; k < 12; k++) begin
            step((k >= 2), 1'b0);
            if (x_clean !== 1'b1) begin
                bad++; $display("FAIL to_low_hold k=%0d: got %b exp 1", k, x_clean);
            end
            total++;
        end
        if (glitch_cnt !== 8'd1) begin
            bad++; $display("FAIL to_low_abort_cnt: got %0d exp 1", glitch_cnt);
        end
        total++;
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 1'b0);
            if (fall_pulse === 1'b1) falls++;
            if (x_clean !== (k < 6)) begin
                bad++; $display("FAIL to_low_fall k=%0d: got %b exp %b", k, x_clean, k < 6);
            end
            total++;
            if (obs_v !== exp_vec()) begin
                bad++; $display("FAIL to_low_model: got %h exp %h", obs_v, exp_vec());
            end
            total++;
        end
        if (falls !== (STROBE_EN ? 1 : 0)) begin
            bad++; $display("FAIL to_low_fall_count: got %0d exp %0d", falls, STROBE_EN ? 1 : 0);
        end
        total++;
    endtask

    task automatic test_clear_priority();
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0);
        step(1'b1, 1'b0); step(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
        if (obs_v !== exp_vec()) begin
            bad++; $display("FAIL clr_pre_model: got %h exp %h", obs_v, exp_vec());
        end
        total++;
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        if (glitch_cnt !== 8'd0) begin
            bad++; $display("FAIL clr_priority: got %0d exp 0", glitch_cnt);
        end
        total++;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        step(1'b1, 1'b0); step(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
        if (glitch_cnt !== 8'd1) begin
            bad++; $display("FAIL clr_then_count: got %0d exp 1", glitch_cnt);
        end
        total++;
    endtask

    task automatic test_stable1();
        int highs = 0, rises = 0, falls = 0;
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            step(k == 0, 1'b0);
            if (x_clean1 === 1'b1) highs++;
            if (rise_pulse1 === 1'b1) rises++;
            if (fall_pulse1 === 1'b1) falls++;
            if (obs_v !== exp_vec()) begin
                bad++; $display("FAIL stable1_model: got %h exp %h", obs_v, exp_vec());
            end
            total++;
        end
        if (highs !== 1) begin
            bad++; $display("FAIL stable1_width: got %0d exp 1", highs);
        end
        total++;
        if ({rises, falls} !== {(STROBE_EN ? 1 : 0), (STROBE_EN ? 1 : 0)}) begin
            bad++; $display("FAIL stable1_strobes: got %0d/%0d exp %0d/%0d", rises, falls,
                            STROBE_EN ? 1 : 0, STROBE_EN ? 1 : 0);
        end
        total++;
    endtask

    task automatic test_random();
        logic lvl;
        for (int seg = 0; seg < 80; seg++) begin
            lvl = 1'($urandom_range(0, 1));
            for (int k = 0; k < int'($urandom_range(1, 9)); k++) begin
                step(lvl, $urandom_range(0, 15) == 0);
                if (obs_v !== exp_vec()) begin
                    bad++; $display("FAIL random_model seg=%0d: got %h exp %h", seg, obs_v, exp_vec());
                end
                total++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_glitch();
        test_to_low_abort();
        test_clear_priority();
        test_stable1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Input conditioning stage for a raw asynchronous level input. It synchronises the input into the `clk` domain and debounces it with a consecutive-sample stability counter. It drives a clean, glitch-free level `x_clean` into the downstream rising-edge pulse generator, which lengthens each qualified rise into a fixed-width active window. It also counts rejected glitches for diagnostics.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flops; legal range 2..4.
- `STABLE_CYCLES`, default 4: consecutive equal synchronised samples needed to accept a level change; legal range 1..(2^`CNT_W`−1).
- `CNT_W`, default 4: stability counter width.
- `clk`  input  1  single clock; all logic on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `x_raw`  input  1  raw asynchronous level, e.g. a switch or external line.
- `x_clean`  output  1  debounced level, registered.
- `rise_pulse`  output  1  one-cycle strobe when `x_clean` goes 0→1.
- `fall_pulse`  output  1  one-cycle strobe when `x_clean` goes 1→0.
- `glitch_cnt`  output  8  saturating count of aborted transitions.
- `glitch_clr`  input  1  synchronous clear of `glitch_cnt`.

## Operation
- **Synchroniser:** `x_raw` passes through a chain of `SYNC_STAGES` flops. The last stage is `s`. No other logic samples `x_raw`.
- **FSM states:** LOW, TO_HIGH, HIGH, TO_LOW. The counter `cnt` is `CNT_W` bits wide.
- **LOW:**
  - `s`=1 and `STABLE_CYCLES`=1 → HIGH.
  - `s`=1 otherwise → TO_HIGH with `cnt`=1.
  - `s`=0 → stay in LOW.
- **TO_HIGH:**
  - `s`=0 → LOW, `cnt`=0, `glitch_cnt`+1.
  - `s`=1 and `cnt`==`STABLE_CYCLES`−1 → HIGH.
  - `s`=1 otherwise → `cnt`+1.
- **HIGH and TO_LOW:** mirror images of LOW and TO_HIGH with `s` polarity inverted. An abort from TO_LOW returns to HIGH and increments `glitch_cnt`.
- **`x_clean`:** registered; equals 1 exactly when the state is HIGH or TO_LOW.
- **`glitch_cnt`:**
  - Saturates at 255.
  - `glitch_clr` has priority over an increment in the same cycle; the result is 0.
- **Reset:** asynchronous and active-low; may assert mid-transition. It forces all synchroniser flops to 0, the state to LOW, `cnt`=0, `x_clean`=0, `rise_pulse`=0, `fall_pulse`=0 and `glitch_cnt`=0. After release, an input held high is treated as a fresh 0→1 change and fully re-qualified.

## Timing
- **Latency:** `x_clean` changes exactly `SYNC_STAGES`+`STABLE_CYCLES` rising edges after the edge that first captures a stable new `x_raw` level. That is 6 edges with default parameters.
- **Glitch rejection:** a pulse on `s` shorter than `STABLE_CYCLES` cycles never reaches `x_clean`.
- **Minimum hold:** `x_clean` holds each level for at least `STABLE_CYCLES` cycles.
- **Strobes:** `rise_pulse`/`fall_pulse` are registered and asserted in the same cycle `x_clean` first shows its new value. They are high for exactly one cycle and are never both high.
- **Output timing:** every output comes directly from a flop, with no combinational path from `x_raw`.

## Configuration
- **`DEBOUNCE_EDGE_STROBE_EN` defined:** `rise_pulse` and `fall_pulse` are generated as specified above.
- **`DEBOUNCE_EDGE_STROBE_EN` undefined:** both ports remain present but are tied to constant 0, and their flops are not instantiated. `x_clean` and `glitch_cnt` behaviour is unchanged.

## Test plan
- **Reset:** assert `rst`=0 mid-TO_HIGH with `x_raw`=1 → all outputs 0 immediately. After release, `x_clean` rises 6 edges later (defaults).
- **Clean rise:** `x_raw` 0→1 held for 20 cycles (defaults) → `x_clean`=1 at edge 6. `rise_pulse` is high for that one cycle only (macro defined).
- **Short glitch:** `x_raw` high for 3 cycles, then low → `x_clean` stays 0 and `glitch_cnt`=1. Repeat 300 times → `glitch_cnt`=255.
- **Fall during TO_LOW abort:** from HIGH, `x_raw` low for 2 cycles, then high → `x_clean` stays 1 and `glitch_cnt` increments by 1. `x_raw` then held low → `x_clean`=0 after 6 edges and `fall_pulse` pulses once.
- **Clear priority:** `glitch_clr`=1 in the same cycle as an abort → `glitch_cnt`=0.
- **`STABLE_CYCLES`=1, macro undefined:** a single-cycle `s` pulse propagates to `x_clean` for exactly 1 cycle. `rise_pulse` and `fall_pulse` are constant 0.
